ps2_key_decoder: RTL and testbench



---
 rtl/ps2_pkg.sv | 22 ++
 rtl/scan_ascii_map.sv | 83 ++++++++
 rtl/ps2_key_decoder.sv | 144 ++++++++++++++
 tb/tb_ps2_key_decoder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 set-2 key decoder.
package ps2_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  typedef enum logic [1:0] {
    IDLE,
    BRK,
    EXT,
    EXT_BRK
  } ps2_state_e;

  typedef struct packed {
    logic [7:0] ascii;
    logic [7:0] scan;
  } fifo_entry_t;

endpackage

// File: rtl/scan_ascii_map.sv
// Combinational set-2 make code to ASCII translation with Shift/Caps handling.
module scan_ascii_map
  import ps2_pkg::*;
(
  input  logic [7:0] scan_code_i,
  input  logic       shift_i,
  input  logic       caps_i,
  output logic [7:0] ascii_o,
  output logic       mapped_o
);

  logic       letter;
  logic [7:0] upper;
  logic [7:0] plain;
  logic [7:0] shifted;

  always_comb begin
    letter   = 1'b0;
    upper    = 8'h00;
    plain    = 8'h00;
    shifted  = 8'h00;
    mapped_o = 1'b1;
    case (scan_code_i)
      8'h1C: begin letter = 1'b1; upper = 8'h41; end
      8'h32: begin letter = 1'b1; upper = 8'h42; end
      8'h21: begin letter = 1'b1; upper = 8'h43; end
      8'h23: begin letter = 1'b1; upper = 8'h44; end
      8'h24: begin letter = 1'b1; upper = 8'h45; end
      8'h2B: begin letter = 1'b1; upper = 8'h46; end
      8'h34: begin letter = 1'b1; upper = 8'h47; end
      8'h33: begin letter = 1'b1; upper = 8'h48; end
      8'h43: begin letter = 1'b1; upper = 8'h49; end
      8'h3B: begin letter = 1'b1; upper = 8'h4A; end
      8'h42: begin letter = 1'b1; upper = 8'h4B; end
      8'h4B: begin letter = 1'b1; upper = 8'h4C; end
      8'h3A: begin letter = 1'b1; upper = 8'h4D; end
      8'h31: begin letter = 1'b1; upper = 8'h4E; end
      8'h44: begin letter = 1'b1; upper = 8'h4F; end
      8'h4D: begin letter = 1'b1; upper = 8'h50; end
      8'h15: begin letter = 1'b1; upper = 8'h51; end
      8'h2D: begin letter = 1'b1; upper = 8'h52; end
      8'h1B: begin letter = 1'b1; upper = 8'h53; end
      8'h2C: begin letter = 1'b1; upper = 8'h54; end
      8'h3C: begin letter = 1'b1; upper = 8'h55; end
      8'h2A: begin letter = 1'b1; upper = 8'h56; end
      8'h1D: begin letter = 1'b1; upper = 8'h57; end
      8'h22: begin letter = 1'b1; upper = 8'h58; end
      8'h35: begin letter = 1'b1; upper = 8'h59; end
      8'h1A: begin letter = 1'b1; upper = 8'h5A; end
      8'h16: begin plain = 8'h31; shifted = 8'h21; end
      8'h1E: begin plain = 8'h32; shifted = 8'h40; end
      8'h26: begin plain = 8'h33; shifted = 8'h23; end
      8'h25: begin plain = 8'h34; shifted = 8'h24; end
      8'h2E: begin plain = 8'h35; shifted = 8'h25; end
      8'h36: begin plain = 8'h36; shifted = 8'h5E; end
      8'h3D: begin plain = 8'h37; shifted = 8'h26; end
      8'h3E: begin plain = 8'h38; shifted = 8'h2A; end
      8'h46: begin plain = 8'h39; shifted = 8'h28; end
      8'h45: begin plain = 8'h30; shifted = 8'h29; end
      8'h0E: begin plain = 8'h60; shifted = 8'h7E; end
      8'h4E: begin plain = 8'h2D; shifted = 8'h5F; end
      8'h55: begin plain = 8'h3D; shifted = 8'h2B; end
      8'h54: begin plain = 8'h5B; shifted = 8'h7B; end
      8'h5B: begin plain = 8'h5D; shifted = 8'h7D; end
      8'h5D: begin plain = 8'h5C; shifted = 8'h7C; end
      8'h4C: begin plain = 8'h3B; shifted = 8'h3A; end
      8'h52: begin plain = 8'h27; shifted = 8'h22; end
      8'h41: begin plain = 8'h2C; shifted = 8'h3C; end
      8'h49: begin plain = 8'h2E; shifted = 8'h3E; end
      8'h29: begin plain = 8'h20; shifted = 8'h20; end
      default: mapped_o = 1'b0;
    endcase

    // Letters follow Shift XOR Caps; everything else follows Shift alone.
    if (!mapped_o)
      ascii_o = 8'h00;
    else if (letter)
      ascii_o = (shift_i ^ caps_i) ? upper : (upper + 8'h20);
    else
      ascii_o = shift_i ? shifted : plain;
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 byte stream decoder: prefix FSM, modifier tracking, ASCII FIFO.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int REPEAT_EN  = 1,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scan_valid,
  input  logic [7:0]       scan_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_ascii,
  output logic [7:0]       out_scan,
  output logic             shift_held,
  output logic             caps_on,
  output logic [CNT_W-1:0] press_count,
  output logic             overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  ps2_state_e        state_q, state_d;
  logic              lshift_q, lshift_d, rshift_q, rshift_d;
  logic              caps_q, caps_d;
  logic [7:0]        held_q, held_d;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q, count_d;
  logic [CNT_W-1:0]  press_q;
  logic              ovf_q;
  fifo_entry_t       mem_q [FIFO_DEPTH];

  logic              is_make, is_break, push_req, push_ok, pop, full, mapped;
  logic [7:0]        map_ascii;
  fifo_entry_t       head;

  scan_ascii_map u_map (
    .scan_code_i (scan_code),
    .shift_i     (lshift_q | rshift_q),
    .caps_i      (caps_q),
    .ascii_o     (map_ascii),
    .mapped_o    (mapped)
  );

  always_comb begin
    state_d  = state_q;
    lshift_d = lshift_q;
    rshift_d = rshift_q;
    caps_d   = caps_q;
    held_d   = held_q;
    is_make  = 1'b0;
    is_break = 1'b0;
    push_req = 1'b0;
    if (scan_valid) begin
      case (state_q)
        IDLE: begin
          if (scan_code == SC_BREAK)    state_d = BRK;
          else if (scan_code == SC_EXT) state_d = EXT;
          else                          is_make = 1'b1;
        end
        BRK: begin
          is_break = 1'b1;
          state_d  = IDLE;
        end
        EXT:     state_d = (scan_code == SC_BREAK) ? EXT_BRK : IDLE;
        default: state_d = IDLE;
      endcase
    end

    if (is_make) begin
      if (scan_code == SC_LSHIFT) lshift_d = 1'b1;
      else if (scan_code == SC_RSHIFT) rshift_d = 1'b1;
      else if (scan_code == SC_CAPS) begin
        // Typematic repeats of Caps Lock must not re-toggle it.
        if (scan_code != held_q) caps_d = ~caps_q;
        held_d = scan_code;
      end else if (mapped) begin
        push_req = !((REPEAT_EN == 0) && (scan_code == held_q));
        held_d   = scan_code;
      end
    end

    if (is_break) begin
      if (scan_code == SC_LSHIFT) lshift_d = 1'b0;
      if (scan_code == SC_RSHIFT) rshift_d = 1'b0;
      if (scan_code == held_q)    held_d   = 8'h00;
    end
  end

  assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
  assign pop     = out_valid & out_ready;
  assign push_ok = push_req & (!full | pop);

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop)      count_d = count_q + (AW+1)'(1);
    else if (!push_ok && pop) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      lshift_q <= 1'b0;
      rshift_q <= 1'b0;
      caps_q   <= 1'b0;
      held_q   <= 8'h00;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      press_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lshift_q <= lshift_d;
      rshift_q <= rshift_d;
      caps_q   <= caps_d;
      held_q   <= held_d;
      count_q  <= count_d;
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        press_q  <= press_q + CNT_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_req && full && !pop) ovf_q <= 1'b1;
    end
  end

  // Storage carries no reset; occupancy gates what is visible.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= '{ascii: map_ascii, scan: scan_code};
  end

  assign head        = mem_q[rd_ptr_q];
  assign out_valid   = (count_q != '0);
  assign out_ascii   = out_valid ? head.ascii : 8'h00;
  assign out_scan    = out_valid ? head.scan  : 8'h00;
  assign shift_held  = lshift_q | rshift_q;
  assign caps_on     = caps_q;
  assign press_count = press_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench: repeat-enabled and repeat-suppressed decoders share one stimulus.
module tb_ps2_key_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scan_valid = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       out_ready = 1'b0;

  logic       v0, v1, sh0, sh1, cp0, cp1, ov0, ov1;
  logic [7:0] a0, a1, s0, s1, pc0, pc1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ps2_key_decoder #(.FIFO_DEPTH(8), .REPEAT_EN(1), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .scan_valid(scan_valid), .scan_code(scan_code),
    .out_valid(v0), .out_ready(out_ready), .out_ascii(a0), .out_scan(s0),
    .shift_held(sh0), .caps_on(cp0), .press_count(pc0), .overflow(ov0));

  ps2_key_decoder #(.FIFO_DEPTH(8), .REPEAT_EN(0), .CNT_W(8)) dut_norep (
    .clk(clk), .rst(rst), .scan_valid(scan_valid), .scan_code(scan_code),
    .out_valid(v1), .out_ready(out_ready), .out_ascii(a1), .out_scan(s1),
    .shift_held(sh1), .caps_on(cp1), .press_count(pc1), .overflow(ov1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    scan_valid = 1'b1;
    scan_code  = b;
    @(negedge clk);
    scan_valid = 1'b0;
  endtask

  task automatic pop1();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_valid", v0, 0);
    chk("rst_ascii", a0, 0);
    chk("rst_scan", s0, 0);
    chk("rst_shift", sh0, 0);
    chk("rst_caps", cp0, 0);
    chk("rst_count", pc0, 0);
    chk("rst_ovf", ov0, 0);

    // Press/release 'a' with consumer always ready
    out_ready = 1'b1;
    send(8'h1C);
    chk("t1_valid", v0, 1);
    chk("t1_ascii", a0, 8'h61);
    chk("t1_scan", s0, 8'h1C);
    chk("t1_count", pc0, 1);
    send(8'hF0);
    send(8'h1C);
    chk("t1_brk_valid", v0, 0);
    chk("t1_brk_count", pc0, 1);
    out_ready = 1'b0;

    // Shift then Caps Lock
    do_reset();
    send(8'h12);
    chk("t2_shift_on", sh0, 1);
    send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
    chk("t2_shift_off", sh0, 0);
    send(8'h1C);
    chk("t2_count", pc0, 2);
    chk("t2_head_A", a0, 8'h41);
    pop1();
    chk("t2_head_a", a0, 8'h61);
    pop1();
    chk("t2_empty", v0, 0);
    send(8'h58);
    chk("t2_caps_on", cp0, 1);
    send(8'hF0); send(8'h58);
    chk("t2_caps_kept", cp0, 1);
    send(8'h12); send(8'h1C);
    chk("t2_caps_shift", a0, 8'h61);
    chk("t2_norep_count", pc1, 3);
    pop1();

    // Shifted digits/symbols, extended keys, unshifted symbols, unmapped
    do_reset();
    send(8'h12); send(8'h16);
    send(8'h12); send(8'h55);
    chk("t3_bang", a0, 8'h21);
    pop1();
    chk("t3_plus", a0, 8'h2B);
    pop1();
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    chk("t3_ext_valid", v0, 0);
    chk("t3_ext_shift", sh0, 1);
    chk("t3_ext_count", pc0, 2);
    send(8'h1C);
    chk("t3_idle_A", a0, 8'h41);
    pop1();
    send(8'hF0); send(8'h12);
    send(8'h45);
    chk("t3_zero", a0, 8'h30);
    pop1();
    send(8'h52);
    chk("t3_quote", a0, 8'h27);
    pop1();
    send(8'h05);
    chk("t3_unmapped", v0, 0);
    chk("t3_unmapped_cnt", pc0, 5);

    // Typematic repeat handling
    do_reset();
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
    chk("t4_rep_count", pc0, 4);
    chk("t4_norep_count", pc1, 2);
    chk("t4_norep_ascii", a1, 8'h61);
    pop1(); pop1();
    chk("t4_norep_empty", v1, 0);
    chk("t4_rep_left", v0, 1);
    pop1(); pop1();
    chk("t4_rep_empty", v0, 0);

    // Overflow and full push+pop
    do_reset();
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23);
    send(8'h24); send(8'h2B); send(8'h34); send(8'h33);
    chk("t5_full_ovf", ov0, 0);
    chk("t5_full_count", pc0, 8);
    send(8'h43);
    chk("t5_ovf", ov0, 1);
    chk("t5_drop_count", pc0, 8);
    chk("t5_head", a0, 8'h61);
    @(negedge clk);
    out_ready  = 1'b1;
    scan_valid = 1'b1;
    scan_code  = 8'h3B;
    @(negedge clk);
    out_ready  = 1'b0;
    scan_valid = 1'b0;
    chk("t5_pp_count", pc0, 9);
    chk("t5_pp_head", a0, 8'h62);
    for (int i = 0; i < 7; i++) pop1();
    chk("t5_pp_valid7", v0, 1);
    chk("t5_pp_last", a0, 8'h6A);
    pop1();
    chk("t5_pp_empty", v0, 0);

    // Asynchronous reset after a break prefix
    do_reset();
    send(8'h1C); send(8'h12); send(8'hF0);
    #2 rst = 1'b1;
    #1;
    chk("t6_valid", v0, 0);
    chk("t6_ascii", a0, 0);
    chk("t6_shift", sh0, 0);
    chk("t6_count", pc0, 0);
    @(negedge clk);
    rst = 1'b0;
    send(8'h1C);
    chk("t6_make_valid", v0, 1);
    chk("t6_make_ascii", a0, 8'h61);
    chk("t6_make_count", pc0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
